cfu_requant: RTL and testbench

- Output post-processing stage directly downstream of the TPU result buffer (128-bit words, 4 x int32 accumulators per word).
- Per lane: adds bias, then applies the TFLite fixed-point requantization (saturating rounding doubling high-mul, then rounding right shift), adds the output offset and clamps.
- Packs 4 int8 results into one 32-bit word for the CPU read-back path.
- Fully pipelined, valid/ready on both sides, 4-cycle latency.

---
 rtl/cfu_requant.sv | 191 +++++++++++++++++++
 tb/tb_cfu_requant.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cfu_requant.sv
// Requantizes LANES x int32 accumulators to packed int8 (bias, rounding doubling high-mul, rounding shift, offset, clamp); define REQUANT_SAT_CNT_EN for sat_cnt.
// Latency: 4 cycles from input acceptance to out_valid.
// Backpressure: one global enable; out_valid && !out_ready freezes every stage and drops in_ready.
module cfu_requant #(
    parameter int LANES    = 4,
    parameter int OUT_BITS = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*32-1:0]       in_acc,
    input  logic [LANES*32-1:0]       in_bias,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*OUT_BITS-1:0] out_data,
    input  logic                      cfg_we,
    input  logic [2:0]                cfg_addr,
    input  logic [31:0]               cfg_data,
`ifdef REQUANT_SAT_CNT_EN
    output logic [31:0]               sat_cnt,
`endif
    output logic                      idle
);

    localparam int NSW = $clog2(LANES + 1);
    localparam logic signed [63:0] NUDGE_POS = 64'sd1073741824;
    localparam logic signed [63:0] NUDGE_NEG = 64'sd1 - 64'sd1073741824;

    logic signed [31:0] cfg_mult, cfg_off, cfg_min, cfg_max;
    logic signed [5:0]  cfg_shift;

    logic [3:0]             stg_vld;
    logic [LANES-1:0][31:0] s1_x, s3_h, s4_r, x_nxt, h_nxt, r_nxt;
    logic [LANES-1:0][63:0] s2_p, p_nxt;
    logic [LANES-1:0]       s2_exc, exc_nxt;
    logic [LANES*OUT_BITS-1:0] y_nxt;
    logic                   en;
    logic [4:0]             lsh, rsh;
    logic [5:0]             neg_shift;
    logic signed [63:0]     rnd_sum;
    logic [31:0]            rnd_q, mask, rem, thr;
    logic signed [31:0]     hs;
    logic signed [32:0]     y, y_min, y_max;
`ifdef REQUANT_SAT_CNT_EN
    logic [NSW-1:0]         nsat_nxt, out_nsat;
    logic [32:0]            sat_sum;
`endif

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign idle     = !(|stg_vld) && !out_valid;

    // Shift of -32 is the only 6-bit value outside +-31; it clips to a right shift of 31.
    always_comb begin
        neg_shift = -cfg_shift;
        lsh = cfg_shift[5] ? 5'd0 : cfg_shift[4:0];
        rsh = !cfg_shift[5] ? 5'd0 : (neg_shift[5] ? 5'd31 : neg_shift[4:0]);
    end

    always_comb begin
        x_nxt = '0;
        for (int i = 0; i < LANES; i++)
            x_nxt[i] = (in_acc[(LANES-1-i)*32 +: 32] + in_bias[(LANES-1-i)*32 +: 32]) << lsh;
    end

    always_comb begin
        p_nxt   = '0;
        exc_nxt = '0;
        for (int i = 0; i < LANES; i++) begin
            p_nxt[i]   = 64'($signed(s1_x[i])) * 64'(cfg_mult);
            exc_nxt[i] = (s1_x[i] == 32'h8000_0000) && (cfg_mult == 32'h8000_0000);
        end
    end

    // High-mul division by 2^31 truncates toward zero, matching the reference kernel.
    always_comb begin
        h_nxt   = '0;
        rnd_sum = '0;
        rnd_q   = '0;
        for (int i = 0; i < LANES; i++) begin
            rnd_sum  = $signed(s2_p[i]) + (s2_p[i][63] ? NUDGE_NEG : NUDGE_POS);
            rnd_q    = rnd_sum[62:31] + {31'd0, rnd_sum[63] && (rnd_sum[30:0] != 31'd0)};
            h_nxt[i] = s2_exc[i] ? 32'h7FFF_FFFF : rnd_q;
        end
    end

    always_comb begin
        r_nxt = '0;
        mask  = '0;
        rem   = '0;
        thr   = '0;
        hs    = '0;
        for (int i = 0; i < LANES; i++) begin
            mask     = (32'd1 << rsh) - 32'd1;
            rem      = s3_h[i] & mask;
            thr      = (mask >> 1) + {31'd0, s3_h[i][31]};
            hs       = $signed(s3_h[i]) >>> rsh;
            r_nxt[i] = hs + {31'd0, rem > thr};
        end
    end

    // Max clamp last, so an inverted range yields act_max.
    always_comb begin
        y_nxt = '0;
        y     = '0;
        y_min = 33'(cfg_min);
        y_max = 33'(cfg_max);
`ifdef REQUANT_SAT_CNT_EN
        nsat_nxt = '0;
`endif
        for (int i = 0; i < LANES; i++) begin
            y = 33'($signed(s4_r[i])) + 33'(cfg_off);
            if (y < y_min || (y >= y_min && y_min > y_max)) begin
`ifdef REQUANT_SAT_CNT_EN
                nsat_nxt = nsat_nxt + NSW'(1);
`endif
                y = (y < y_min) ? y_min : y;
            end else if (y > y_max) begin
`ifdef REQUANT_SAT_CNT_EN
                nsat_nxt = nsat_nxt + NSW'(1);
`endif
            end
            if (y > y_max)
                y = y_max;
            y_nxt[(LANES-1-i)*OUT_BITS +: OUT_BITS] = y[OUT_BITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_vld   <= '0;
            s1_x      <= '0;
            s2_p      <= '0;
            s2_exc    <= '0;
            s3_h      <= '0;
            s4_r      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            stg_vld   <= {stg_vld[2:0], in_valid};
            s1_x      <= x_nxt;
            s2_p      <= p_nxt;
            s2_exc    <= exc_nxt;
            s3_h      <= h_nxt;
            s4_r      <= r_nxt;
            out_valid <= stg_vld[3];
            out_data  <= y_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_mult  <= 32'sh4000_0000;
            cfg_shift <= '0;
            cfg_off   <= '0;
            cfg_min   <= -32'sd128;
            cfg_max   <= 32'sd127;
        end else if (cfg_we && idle) begin
            case (cfg_addr)
                3'd0:    cfg_mult  <= cfg_data;
                3'd1:    cfg_shift <= cfg_data[5:0];
                3'd2:    cfg_off   <= cfg_data;
                3'd3:    cfg_min   <= cfg_data;
                3'd4:    cfg_max   <= cfg_data;
                default: ;
            endcase
        end
    end

`ifdef REQUANT_SAT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_nsat <= '0;
        else if (en)
            out_nsat <= nsat_nxt;
    end

    assign sat_sum = {1'b0, sat_cnt} + 33'(out_nsat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_cnt <= '0;
        else if (cfg_we && idle && cfg_addr == 3'd7)
            sat_cnt <= '0;
        else if (out_valid && out_ready)
            sat_cnt <= sat_sum[32] ? 32'hFFFF_FFFF : sat_sum[31:0];
    end
`endif

endmodule

// File: tb/tb_cfu_requant.sv
// Directed bench for cfu_requant: hand-computed vectors, latency, backpressure, config gating and reset.
module tb_cfu_requant;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, cfg_we, idle;
    logic [127:0] in_acc, in_bias;
    logic [31:0]  out_data, cfg_data;
    logic [2:0]   cfg_addr;
`ifdef REQUANT_SAT_CNT_EN
    logic [31:0]  sat_cnt;
`endif

    int checks = 0;
    int errors = 0;

    cfu_requant dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_acc    (in_acc),
        .in_bias   (in_bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
`ifdef REQUANT_SAT_CNT_EN
        .sat_cnt   (sat_cnt),
`endif
        .idle      (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
        return {a, b, c, d};
    endfunction

    task automatic cfg(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // One beat into an idle pipe; checks acceptance, 4-cycle latency and data.
    task automatic run_beat(input logic [127:0] acc, input logic [127:0] bias,
                            input logic [31:0] exp, input string tag);
        int lat;
        @(negedge clk);
        in_acc = acc; in_bias = bias; in_valid = 1'b1; out_ready = 1'b1;
        #1 check(in_ready, 1, {tag, "_in_ready"});
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check(lat, 4, {tag, "_latency"});
        check(out_data, exp, {tag, "_data"});
    endtask

    function automatic logic [127:0] bp_vec(input int k);
        int kk = k + 1;
        return pack4(2 * kk, 4 * kk, -2 * kk, 20 + 2 * kk);
    endfunction

    function automatic logic [31:0] bp_exp(input int k);
        int kk = k + 1;
        return {8'(kk), 8'(2 * kk), 8'(-kk), 8'(10 + kk)};
    endfunction

    initial begin
        int sent, got, n;
        logic [31:0] held;
        logic prev_stall;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cfg_we = 1'b0;
        cfg_addr = '0; cfg_data = '0; in_acc = '0; in_bias = '0;
        #12;
        check(in_ready, 1, "rst_in_ready");
        check(out_valid, 0, "rst_out_valid");
        check(out_data, 0, "rst_out_data");
        check(idle, 1, "rst_idle");
`ifdef REQUANT_SAT_CNT_EN
        check(sat_cnt, 0, "rst_sat_cnt");
`endif
        @(negedge clk);
        rst_n = 1'b1;

        cfg(3'd2, -128);
        run_beat(pack4(100, 100, 100, 100), '0, 32'hB2B2_B2B2, "basic");

        cfg(3'd2, 0);
        run_beat(pack4(1000000, -1000000, 20, -20), pack4(0, 0, 4, -4), 32'h7F80_0CF4, "bias_clamp");
`ifdef REQUANT_SAT_CNT_EN
        @(negedge clk);
        check(sat_cnt, 2, "sat_cnt_two");
        cfg(3'd7, 0);
        check(sat_cnt, 0, "sat_cnt_clear");
`endif

        cfg(3'd1, 32'hFFFF_FFFE);
        run_beat(pack4(10, 14, -10, -14), '0, 32'h0102_FFFE, "round_shift");

        cfg(3'd1, 1);
        run_beat(pack4(10, -10, 3, 0), '0, 32'h0AF6_0300, "left_shift");

        cfg(3'd1, 0);
        cfg(3'd0, 32'h8000_0000);
        run_beat(pack4(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000), '0,
                 32'h7F7F_7F7F, "overflow_exc");

        cfg(3'd0, 32'h4000_0000);
        cfg(3'd3, 10);
        cfg(3'd4, 5);
        run_beat(pack4(100, -100, 0, 8), '0, 32'h0505_0505, "min_gt_max");
        cfg(3'd3, -128);
        cfg(3'd4, 127);

        // Eight back-to-back beats, downstream stalls for three cycles mid-stream.
        sent = 0; got = 0; held = '0; prev_stall = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 6 && cyc <= 8);
            in_valid  = (sent < 8);
            in_acc    = bp_vec(sent);
            in_bias   = '0;
            #1;
            if (out_valid && !out_ready) begin
                check(in_ready, 0, "bp_in_ready_low");
                if (prev_stall)
                    check(out_data, held, "bp_stable");
                held = out_data;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                check(out_data, bp_exp(got), "bp_data");
                got++;
            end
            if (in_valid && in_ready)
                sent++;
        end
        in_valid = 1'b0;
        check(got, 8, "bp_count");
        @(negedge clk);
        #1 check(out_valid, 0, "bp_no_dup");

        // Multiplier write while a beat is in flight must be ignored.
        @(negedge clk);
        in_acc = pack4(100, 100, 100, 100); in_bias = '0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 32'h2000_0000;
        #1 check(idle, 0, "gate_busy");
        @(negedge clk);
        cfg_we = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(out_data, 32'h3232_3232, "gate_inflight");
        run_beat(pack4(100, 100, 100, 100), '0, 32'h3232_3232, "gate_after");

        // Reset with three beats in flight and a stalled output.
        cfg(3'd2, -128);
        cfg(3'd0, 32'h2000_0000);
        @(negedge clk);
        out_ready = 1'b0; in_acc = pack4(100, 100, 100, 100); in_bias = '0; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(out_valid, 1, "rst_pre_valid");
        #2 rst_n = 1'b0;
        #1;
        check(out_valid, 0, "rst_mid_out_valid");
        check(idle, 1, "rst_mid_idle");
        check(in_ready, 1, "rst_mid_in_ready");
        check(out_data, 0, "rst_mid_out_data");
        @(negedge clk);
        rst_n = 1'b1;
        run_beat(pack4(100, 100, 100, 100), '0, 32'h3232_3232, "rst_defaults");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
